// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the machine word and the ALU operation encoding.
package cpu_types_pkg;

    parameter int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'h0,
        ALU_SRL  = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } aluop_t;

endpackage

// File: rtl/alu_mult_seq.sv
// Iterative shift-add multiplier that borrows the shared ALU for every add and shift.
// Returns the low 32 bits of mcand*mplier; one iteration is three cycles (ADD, SHL, SHR).
module alu_mult_seq
    import cpu_types_pkg::*;
(
    input  logic   CLK,
    input  logic   nRST,
    input  logic   start,
    input  word_t  mcand,
    input  word_t  mplier,
    output logic   busy,
    output logic   done,
    output word_t  product,
    output aluop_t alu_op,
    output word_t  alu_a,
    output word_t  alu_b,
    input  word_t  alu_out
);

    typedef enum logic [2:0] {
        StIdle,
        StAdd,
        StShl,
        StShr,
        StDone
    } state_t;

    state_t state_q, state_d;
    word_t  acc_q, acc_d;
    word_t  mc_q, mc_d;
    word_t  mp_q, mp_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        alu_op  = ALU_ADD;
        alu_a   = '0;
        alu_b   = '0;
        busy    = 1'b1;
        done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    acc_d   = '0;
                    mc_d    = mcand;
                    mp_d    = mplier;
                    state_d = (mplier != '0) ? StAdd : StDone;
                end
            end
            StAdd: begin
                // Skipped partial products still present a benign 0+0 to the ALU.
                if (mp_q[0]) begin
                    alu_a = acc_q;
                    alu_b = mc_q;
                    acc_d = alu_out;
                end
                state_d = StShl;
            end
            StShl: begin
                alu_op  = ALU_SLL;
                alu_a   = mc_q;
                alu_b   = 32'd1;
                mc_d    = alu_out;
                state_d = StShr;
            end
            StShr: begin
                // Multiplier running out of set bits ends the loop; no iteration counter.
                alu_op  = ALU_SRL;
                alu_a   = mp_q;
                alu_b   = 32'd1;
                mp_d    = alu_out;
                state_d = (alu_out != '0) ? StAdd : StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign product = acc_q;

    a_done_busy: assert property (@(posedge CLK) disable iff (!nRST) done |-> busy);
    a_done_pulse: assert property (@(posedge CLK) disable iff (!nRST) done |=> !done);

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with a behavioural ALU closing the operand loop.
module tb_alu_mult_seq;
    import cpu_types_pkg::*;

    logic   CLK = 1'b0;
    logic   nRST = 1'b0;
    logic   start = 1'b0;
    word_t  mcand = '0;
    word_t  mplier = '0;
    logic   busy;
    logic   done;
    word_t  product;
    aluop_t alu_op;
    word_t  alu_a;
    word_t  alu_b;
    word_t  alu_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        int          cyc;
    } vec_t;

    vec_t vecs[10];

    always #5 CLK = ~CLK;

    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD: alu_out = alu_a + alu_b;
            ALU_SLL: alu_out = alu_a << alu_b[4:0];
            ALU_SRL: alu_out = alu_a >> alu_b[4:0];
            default: alu_out = '0;
        endcase
    end

    alu_mult_seq dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product),
        .alu_op  (alu_op),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_out (alu_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the first IDLE
    // cycle after done, so consecutive calls exercise back-to-back starts.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_p, input int exp_cyc, input int inj);
        int          done_cyc;
        int          busy_bad;
        int          drv_bad;
        logic [31:0] m_acc;
        logic [31:0] m_mc;
        logic [31:0] m_mp;
        logic [31:0] e_a;
        logic [31:0] e_b;
        aluop_t      e_op;
        done_cyc = 0;
        busy_bad = 0;
        drv_bad  = 0;
        m_acc    = '0;
        m_mc     = a;
        m_mp     = b;
        start    = 1'b1;
        mcand    = a;
        mplier   = b;
        @(posedge CLK);
        @(negedge CLK);
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
        for (int k = 1; k <= 120 && done_cyc == 0; k++) begin
            if (k > 1) @(negedge CLK);
            start = (k == inj);
            if (k == inj) begin
                mcand  = 32'd9;
                mplier = 32'd9;
            end
            if (busy !== 1'b1) busy_bad++;
            if (product !== m_acc) drv_bad++;
            if (done === 1'b1) begin
                done_cyc = k;
                e_op = ALU_ADD;
                e_a  = '0;
                e_b  = '0;
            end else begin
                case ((k - 1) % 3)
                    0: begin
                        e_op = ALU_ADD;
                        e_a  = m_mp[0] ? m_acc : 32'd0;
                        e_b  = m_mp[0] ? m_mc : 32'd0;
                        if (m_mp[0]) m_acc = m_acc + m_mc;
                    end
                    1: begin
                        e_op = ALU_SLL;
                        e_a  = m_mc;
                        e_b  = 32'd1;
                        m_mc = m_mc << 1;
                    end
                    default: begin
                        e_op = ALU_SRL;
                        e_a  = m_mp;
                        e_b  = 32'd1;
                        m_mp = m_mp >> 1;
                    end
                endcase
            end
            if (alu_op !== e_op || alu_a !== e_a || alu_b !== e_b) drv_bad++;
        end
        start = 1'b0;
        check({name, " done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
        check({name, " product"}, product, exp_p);
        check({name, " busy_gaps"}, 32'(busy_bad), 32'd0);
        check({name, " alu_drive_errs"}, 32'(drv_bad), 32'd0);
        @(negedge CLK);
        check({name, " done_after"}, {31'd0, done}, 32'd0);
        check({name, " busy_after"}, {31'd0, busy}, 32'd0);
        check({name, " product_held"}, product, exp_p);
    endtask

    initial begin
        int done_seen;

        vecs[0] = '{a: 32'd3,          b: 32'd5,          p: 32'd15,         cyc: 10};
        vecs[1] = '{a: 32'h0000_1234,  b: 32'd0,          p: 32'd0,          cyc: 1};
        vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  p: 32'h0000_0001,  cyc: 97};
        vecs[3] = '{a: 32'hFFFF_FFFD,  b: 32'd7,          p: 32'hFFFF_FFEB,  cyc: 10};
        vecs[4] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  p: 32'h0000_0000,  cyc: 52};
        vecs[5] = '{a: 32'd7,          b: 32'd1,          p: 32'd7,          cyc: 4};
        vecs[6] = '{a: 32'h1234_5678,  b: 32'h0000_0100,  p: 32'h3456_7800,  cyc: 28};
        vecs[7] = '{a: 32'hDEAD_BEEF,  b: 32'h8000_0000,  p: 32'h8000_0000,  cyc: 97};
        vecs[8] = '{a: 32'd100,        b: 32'd1000,       p: 32'h0001_86A0,  cyc: 31};
        vecs[9] = '{a: 32'd2,          b: 32'd2,          p: 32'd4,          cyc: 7};

        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset product", product, 32'd0);
        check("reset alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
        check("reset alu_a", alu_a, 32'd0);
        check("reset alu_b", alu_b, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].cyc, 0);
        end

        // 9x9 start in cycle 4 must be dropped; a real 9x9 follows in the first IDLE cycle.
        run_op("busy_ignore 3x5", 32'd3, 32'd5, 32'd15, 10, 4);
        run_op("back_to_back 9x9", 32'd9, 32'd9, 32'd81, 13, 0);

        start  = 1'b1;
        mcand  = 32'h0001_0000;
        mplier = 32'h0001_0000;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        nRST = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset product", product, 32'd0);
        check("midreset alu_a", alu_a, 32'd0);
        check("midreset alu_b", alu_b, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("midreset no_done", 32'(done_seen), 32'd0);
        run_op("post_reset 2x2", 32'd2, 32'd2, 32'd4, 7, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
